// File: rtl/cic_int_pipe.sv
// Time-multiplexed CIC integrator cascade: STAGES integrators per channel, one stage per cycle,
// with per-channel clear, post-reset zeroing sweep and a registered decimation read port.
module cic_int_pipe #(
  parameter int WIDTH    = 22,
  parameter int CHANNELS = 8,
  parameter int STAGES   = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  output logic                        in_ready,
  input  logic                        wr_en,
  input  logic                        clr_en,
  input  logic [$clog2(CHANNELS)-1:0] channel,
  input  logic [WIDTH-1:0]            data_in,
  output logic                        out_valid,
  output logic [$clog2(CHANNELS)-1:0] out_channel,
  output logic [WIDTH-1:0]            data_out,
  input  logic                        read_en,
  input  logic [$clog2(CHANNELS)-1:0] read_channel,
  output logic                        rd_valid,
  output logic [WIDTH-1:0]            read_data
);

  localparam int CW = $clog2(CHANNELS);
  localparam int PS = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  logic [WIDTH-1:0] acc_q [STAGES][CHANNELS];
  logic [WIDTH-1:0] acc_d [STAGES][CHANNELS];

  logic [CW-1:0]    init_cnt_q, init_cnt_d;
  logic             init_busy_q, init_busy_d;
  logic             in_ready_q, in_ready_d;

  logic [PS-1:0]    p_vld_q, p_vld_d;
  logic [PS-1:0]    p_clr_q, p_clr_d;
  logic [CW-1:0]    p_ch_q [PS];
  logic [CW-1:0]    p_ch_d [PS];
  logic [WIDTH-1:0] p_x_q [PS];
  logic [WIDTH-1:0] p_x_d [PS];

  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_channel_q, out_channel_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;

  logic             s_vld [STAGES];
  logic             s_clr [STAGES];
  logic [CW-1:0]    s_ch  [STAGES];
  logic [WIDTH-1:0] s_x   [STAGES];
  logic [WIDTH-1:0] s_sum [STAGES];

  // Stage operands: stage 0 takes the accepted request, later stages the previous stage's register.
  always_comb begin
    s_vld[0] = in_ready_q & (wr_en | clr_en) & ~resetn;
    s_clr[0] = clr_en;
    s_ch[0]  = channel;
    s_x[0]   = data_in;
    for (int k = 1; k < STAGES; k++) begin
      s_vld[k] = p_vld_q[k-1] & ~resetn;
      s_clr[k] = p_clr_q[k-1];
      s_ch[k]  = p_ch_q[k-1];
      s_x[k]   = p_x_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (s_clr[k]) begin
        s_sum[k] = {WIDTH{1'b0}};
      end else begin
        s_sum[k] = acc_q[k][s_ch[k]] + s_x[k];
      end
    end
  end

  // Accumulator writes: the sweep owns the file until in_ready, so it never meets a live operation.
  always_comb begin
    acc_d = acc_q;
    if (init_busy_q && !resetn) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_d[k][init_cnt_q] = {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (s_vld[k]) begin
          acc_d[k][s_ch[k]] = s_sum[k];
        end else begin
          acc_d[k][s_ch[k]] = acc_q[k][s_ch[k]];
        end
      end
    end
  end

  // Sweep counter, pipeline registers, output and read-port next state.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_busy_d = init_busy_q;
    in_ready_d  = in_ready_q;
    if (init_busy_q) begin
      if (init_cnt_q == LAST_CH) begin
        init_busy_d = 1'b0;
        in_ready_d  = 1'b1;
      end else begin
        init_cnt_d  = init_cnt_q + CW'(1);
      end
    end else begin
      init_busy_d = 1'b0;
    end

    for (int k = 0; k < PS; k++) begin
      if (k < STAGES - 1) begin
        p_vld_d[k] = s_vld[k];
        p_clr_d[k] = s_clr[k];
        p_ch_d[k]  = s_ch[k];
        p_x_d[k]   = s_sum[k];
      end else begin
        p_vld_d[k] = 1'b0;
        p_clr_d[k] = 1'b0;
        p_ch_d[k]  = {CW{1'b0}};
        p_x_d[k]   = {WIDTH{1'b0}};
      end
    end

    out_valid_d = s_vld[STAGES-1] & ~s_clr[STAGES-1];
    if (out_valid_d) begin
      out_channel_d = s_ch[STAGES-1];
      data_out_d    = s_sum[STAGES-1];
    end else begin
      out_channel_d = out_channel_q;
      data_out_d    = data_out_q;
    end

    rd_valid_d  = read_en;
    read_data_d = acc_q[STAGES-1][read_channel];
  end

  // Accumulator file: no reset, zeroed by the post-reset sweep.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // Control and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      init_cnt_q    <= {CW{1'b0}};
      init_busy_q   <= 1'b1;
      in_ready_q    <= 1'b0;
      p_vld_q       <= {PS{1'b0}};
      p_clr_q       <= {PS{1'b0}};
      for (int k = 0; k < PS; k++) begin
        p_ch_q[k] <= {CW{1'b0}};
        p_x_q[k]  <= {WIDTH{1'b0}};
      end
      out_valid_q   <= 1'b0;
      out_channel_q <= {CW{1'b0}};
      data_out_q    <= {WIDTH{1'b0}};
      rd_valid_q    <= 1'b0;
      read_data_q   <= {WIDTH{1'b0}};
    end else begin
      init_cnt_q    <= init_cnt_d;
      init_busy_q   <= init_busy_d;
      in_ready_q    <= in_ready_d;
      p_vld_q       <= p_vld_d;
      p_clr_q       <= p_clr_d;
      for (int k = 0; k < PS; k++) begin
        p_ch_q[k] <= p_ch_d[k];
        p_x_q[k]  <= p_x_d[k];
      end
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      data_out_q    <= data_out_d;
      rd_valid_q    <= rd_valid_d;
      read_data_q   <= read_data_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign data_out    = data_out_q;
  assign rd_valid    = rd_valid_q;
  assign read_data   = read_data_q;

endmodule

// File: doc/cic_int_pipe.md
Name: cic_int_pipe

Overview:
Next-generation time-multiplexed CIC integrator section for the mic-array decimation path. It implements a cascade of STAGES integrators per channel for CHANNELS interleaved channels. Per-channel state lives in one register file per stage, and the cascade is pipelined one stage per cycle. It adds tagged output valid, a per-channel clear, a post-reset clear sweep with a ready flag, and a decimation read port. It sits between the PDM/sample front end and the comb section.

Parameters:
WIDTH, 22, signed width of data_in, all accumulators and outputs
CHANNELS, 8, number of interleaved channels (>=2)
STAGES, 4, number of cascaded integrators (>=1)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active-high (despite the name)
in_ready  output  1  high when samples/clears are accepted
wr_en  input  1  sample strobe, qualified by in_ready
clr_en  input  1  per-channel clear strobe, qualified by in_ready
channel  input  $clog2(CHANNELS)  channel of the wr_en/clr_en operation
data_in  input  WIDTH  signed input sample
out_valid  output  1  integrator-cascade result valid
out_channel  output  $clog2(CHANNELS)  channel tag of data_out
data_out  output  WIDTH  signed last-stage result
read_en  input  1  decimation read strobe
read_channel  input  $clog2(CHANNELS)  channel to read
rd_valid  output  1  read_data valid
read_data  output  WIDTH  last-stage accumulator of read_channel

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on resetn. No other clock or async logic.
- Reset: out_valid=0, out_channel=0, data_out=0, rd_valid=0, read_data=0, in_ready=0, and all pipeline valid/clear flags are cleared.
- Init sweep: after resetn deasserts, a counter 0..CHANNELS-1 writes zero to every stage accumulator of one channel per cycle. in_ready rises the cycle after the last channel is written, i.e. in_ready=1 exactly CHANNELS cycles after the first cycle with resetn low. Reasserting resetn mid-sweep restarts the sweep from channel 0.
- Ignored requests: wr_en/clr_en while in_ready=0 are dropped. read_en during the sweep is still answered, with whatever the accumulator holds.
- Accepted operation: on an accepted wr_en or clr_en, (channel, data, op) enters stage 1. Each stage k (1..STAGES) works on the operation of its slot in a single cycle:
  - sample: acc_k[ch] <= acc_k[ch] + x_{k-1}, where x_0=data_in. x_k = the new acc_k value is passed to stage k+1 next cycle.
  - clear: acc_k[ch] <= 0, and x_k=0 is passed on.
- Same channel back-to-back: every cycle is legal. Each stage completes its read-modify-write within one cycle, so there is no hazard.
- Simultaneous wr_en and clr_en: clear wins and the sample is dropped.
- Output: out_valid pulses STAGES cycles after acceptance, for samples only. Clears produce no out_valid. data_out=x_STAGES and out_channel=ch. data_out and out_channel hold their values when out_valid=0.
- Arithmetic: two's-complement modulo 2^WIDTH wrap-around, with no saturation. CIC correctness depends on the wrap.
- Read port: rd_valid and read_data are registered, with 1-cycle latency. read_data=acc_STAGES[read_channel] as it was before any write in the same cycle, i.e. a colliding write is not forwarded. rd_valid follows read_en and is independent of in_ready.
- Throughput: one operation per cycle, no backpressure once in_ready=1.

Test Plan:
1. Reset sweep: CHANNELS=8, hold resetn high 3 cycles, then low -> in_ready rises after 8 cycles. wr_en one cycle earlier -> ignored, no out_valid.
2. Cascade: WIDTH=16, STAGES=2, CHANNELS=4. Feed data_in=1 on ch0 for 4 consecutive cycles -> out_valid at acceptance+2 each time, data_out=1,3,6,10, out_channel=0.
3. Interleave: alternate ch1=+2 and ch2=-1 for 6 cycles, STAGES=1 -> ch1 outputs 2,4,6 and ch2 outputs -1,-2,-3, each tagged correctly. ch0/ch3 read back 0.
4. Wrap: WIDTH=8, STAGES=1. Feed 100 then 100 on ch3 -> data_out=100 then -56.
5. Clear: after test 2, clr_en ch0 together with wr_en -> no out_valid. Next sample 1 -> data_out=1. Other channels unaffected.
6. Read collision: STAGES=1, ch0 acc=5. Same cycle: wr_en ch0 data 3 and read_en ch0 -> read_data=5, rd_valid next cycle. A read the following cycle returns 8.
